// File: rtl/leaky_integrator_scheduler.sv
// Time-multiplexed leaky integrator: one shared multiplier/adder serves NCH channels,
// granted round-robin and sequenced RD -> MUL_A -> ADD -> MUL_C -> OUT.
module leaky_integrator_scheduler #(
   parameter int WI        = 12,
   parameter int WF        = 12,
   parameter int NCH       = 4,
   parameter int ALPHA     = 3686,
   parameter int ALPHA_CAP = 410
) (
   input  logic                          Clk,
   input  logic                          RESET,
   input  logic [NCH-1:0]                In_req,
   input  logic [NCH*(WI+WF)-1:0]        In_data,
   output logic [NCH-1:0]                In_ack,
   input  logic [NCH-1:0]                Clr,
   output logic                          Out_valid,
   output logic [$clog2(NCH)-1:0]        Out_ch,
   output logic [WI+WF-1:0]              Out_data,
   output logic                          Out_ovf,
   output logic                          Busy
);

   localparam int W  = WI + WF;
   localparam int CW = $clog2(NCH);

   localparam logic signed [W-1:0]   ALPHA_W = ALPHA[W-1:0];
   localparam logic signed [W-1:0]   CAP_W   = ALPHA_CAP[W-1:0];
   localparam logic signed [W-1:0]   MAXW    = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]   MINW    = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W-1:0] MAX2    = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] MIN2    = {{(W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [CW-1:0]         LAST    = CW'(NCH - 1);
   localparam logic [CW-1:0]         ONE     = CW'(1);
   localparam logic [NCH-1:0]        ONEHOT0 = {{(NCH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      MUL_A = 3'd2,
      ADD   = 3'd3,
      MUL_C = 3'd4,
      OUT   = 3'd5
   } state_t;

   // Returns {overflow, value}: (a*b) >>> WF floored, clamped to W bits.
   function automatic logic [W:0] mul_sat(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
      logic signed [2*W-1:0] p_s;
      logic signed [2*W-1:0] q_s;
      logic [W:0]            r_s;
      p_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      q_s = p_s >>> WF;
      if (q_s > MAX2) begin
         r_s = {1'b1, MAXW};
      end else if (q_s < MIN2) begin
         r_s = {1'b1, MINW};
      end else begin
         r_s = {1'b0, q_s[W-1:0]};
      end
      return r_s;
   endfunction

   // Returns {overflow, value}: a + b clamped to W bits.
   function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
      logic [W:0] s_s;
      logic [W:0] r_s;
      s_s = {a[W-1], a} + {b[W-1], b};
      if (s_s[W] != s_s[W-1]) begin
         r_s = s_s[W] ? {1'b1, MINW} : {1'b1, MAXW};
      end else begin
         r_s = {1'b0, s_s[W-1:0]};
      end
      return r_s;
   endfunction

   state_t                state_r;
   state_t                next_s;
   logic [CW-1:0]         ptr_r;
   logic [CW-1:0]         ch_r;
   logic signed [W-1:0]   x_r;
   logic signed [W-1:0]   opnd_r;
   logic signed [W-1:0]   prod_r;
   logic signed [W-1:0]   sum_r;
   logic                  ovf_r;
   logic signed [W-1:0]   acc_r [NCH];

   logic                  gfound_s;
   logic [CW-1:0]         gidx_s;
   logic [W:0]            mul_a_s;
   logic [W:0]            add_s;
   logic [W:0]            mul_c_s;

   assign mul_a_s = mul_sat(opnd_r, ALPHA_W);
   assign add_s   = add_sat(x_r, prod_r);
   assign mul_c_s = mul_sat(sum_r, CAP_W);

   // Round-robin search: first requester at or after the pointer, wrapping at NCH-1.
   always_comb begin
      int            idx;
      logic [CW-1:0] idx_s;
      logic          hit_s;
      gfound_s = 1'b0;
      gidx_s   = {CW{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         idx      = int'(ptr_r) + i;
         idx      = (idx >= NCH) ? (idx - NCH) : idx;
         idx_s    = CW'(idx);
         hit_s    = !gfound_s && In_req[idx_s];
         gidx_s   = hit_s ? idx_s : gidx_s;
         gfound_s = gfound_s | hit_s;
      end
   end

   // Next-state and grant acknowledge.
   always_comb begin
      next_s = state_r;
      In_ack = {NCH{1'b0}};
      case (state_r)
         IDLE: begin
            if (gfound_s && RESET) begin
               next_s = RD;
               In_ack = ONEHOT0 << gidx_s;
            end else begin
               next_s = IDLE;
            end
         end
         RD:      next_s = MUL_A;
         MUL_A:   next_s = ADD;
         ADD:     next_s = MUL_C;
         MUL_C:   next_s = OUT;
         OUT:     next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // State register and busy flag.
   always_ff @(posedge Clk) begin
      if (!RESET) begin
         state_r <= IDLE;
         Busy    <= 1'b0;
      end else begin
         state_r <= next_s;
         Busy    <= (next_s != IDLE);
      end
   end

   // Datapath pipeline registers and result outputs.
   always_ff @(posedge Clk) begin
      if (!RESET) begin
         ptr_r     <= {CW{1'b0}};
         ch_r      <= {CW{1'b0}};
         x_r       <= {W{1'b0}};
         opnd_r    <= {W{1'b0}};
         prod_r    <= {W{1'b0}};
         sum_r     <= {W{1'b0}};
         ovf_r     <= 1'b0;
         Out_valid <= 1'b0;
         Out_ch    <= {CW{1'b0}};
         Out_data  <= {W{1'b0}};
         Out_ovf   <= 1'b0;
      end else begin
         Out_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (gfound_s) begin
                  ch_r  <= gidx_s;
                  x_r   <= In_data[gidx_s*W +: W];
                  ptr_r <= (gidx_s == LAST) ? {CW{1'b0}} : gidx_s + ONE;
               end else begin
                  ptr_r <= ptr_r;
               end
            end
            RD:    opnd_r <= acc_r[ch_r];
            MUL_A: begin
               prod_r <= mul_a_s[W-1:0];
               ovf_r  <= mul_a_s[W];
            end
            ADD: begin
               sum_r <= add_s[W-1:0];
               ovf_r <= ovf_r | add_s[W];
            end
            MUL_C: begin
               Out_valid <= 1'b1;
               Out_ch    <= ch_r;
               Out_data  <= mul_c_s[W-1:0];
               Out_ovf   <= ovf_r | mul_c_s[W];
            end
            default: Out_valid <= 1'b0;
         endcase
      end
   end

   // Accumulator file: a clear beats a coincident writeback.
   always_ff @(posedge Clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (!RESET || Clr[k]) begin
            acc_r[k] <= {W{1'b0}};
         end else if (state_r == ADD && ch_r == CW'(k)) begin
            acc_r[k] <= add_s[W-1:0];
         end else begin
            acc_r[k] <= acc_r[k];
         end
      end
   end

endmodule

// File: tb/tb_leaky_integrator_scheduler.sv
// Directed bench for leaky_integrator_scheduler: hand-computed Q12.12 results,
// grant order/spacing, saturation, clear-vs-writeback and mid-update reset.
module tb_leaky_integrator_scheduler;

   localparam int W   = 24;
   localparam int NCH = 4;
   localparam int CW  = 2;

   logic              Clk = 1'b0;
   logic              RESET;
   logic [NCH-1:0]    In_req;
   logic [NCH*W-1:0]  In_data;
   logic [NCH-1:0]    In_ack;
   logic [NCH-1:0]    Clr;
   logic              Out_valid;
   logic [CW-1:0]     Out_ch;
   logic [W-1:0]      Out_data;
   logic              Out_ovf;
   logic              Busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_g   = 0;

   int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_y  [8] = '{778, 839679, 410, -839312, 1110, 839679, 778, -839680};
   int exp_o  [8] = '{0, 0, 0, 0, 0, 1, 0, 1};

   leaky_integrator_scheduler dut (
      .Clk       (Clk),
      .RESET     (RESET),
      .In_req    (In_req),
      .In_data   (In_data),
      .In_ack    (In_ack),
      .Clr       (Clr),
      .Out_valid (Out_valid),
      .Out_ch    (Out_ch),
      .Out_data  (Out_data),
      .Out_ovf   (Out_ovf),
      .Busy      (Busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_data(input int ch, input int v);
      In_data[ch*W +: W] = v[W-1:0];
   endtask

   // Waits for the grant of ch, then checks latency and the result.
   task automatic update(input int ch, input int ey, input int eo,
                         input bit clr_add, input bit drop_req, input bit chk_gap);
      int             n;
      logic [NCH-1:0] oh;
      oh     = 4'b0000;
      oh[ch] = 1'b1;
      #1;
      n = 0;
      while (In_ack === 4'b0000 && n < 40) begin
         tick();
         n++;
      end
      chk("ack_onehot", In_ack, oh);
      if (chk_gap) chk("grant_gap", cyc - last_g, 6);
      last_g = cyc;
      n = 0;
      while (n < 12) begin
         tick();
         n++;
         if (n == 1) begin
            chk("busy", Busy, 1);
            if (drop_req) In_req[ch] = 1'b0;
         end
         if (clr_add && n == 3) Clr[ch] = 1'b1;
         if (n == 4) Clr = 4'b0000;
         if (Out_valid === 1'b1) break;
      end
      chk("latency", n, 5);
      chk("out_ch", Out_ch, ch);
      chk("out_data", $signed(Out_data), ey);
      chk("out_ovf", Out_ovf, eo);
      tick();
      chk("valid_pulse", Out_valid, 0);
      chk("data_hold", $signed(Out_data), ey);
   endtask

   initial begin
      int n;
      RESET   = 1'b0;
      In_req  = 4'b0001;
      In_data = {(NCH*W){1'b0}};
      Clr     = 4'b0000;
      repeat (3) tick();
      chk("rst_ack", In_ack, 0);
      chk("rst_valid", Out_valid, 0);
      chk("rst_ch", Out_ch, 0);
      chk("rst_data", $signed(Out_data), 0);
      chk("rst_ovf", Out_ovf, 0);
      chk("rst_busy", Busy, 0);
      In_req = 4'b0000;
      tick();
      RESET = 1'b1;
      tick();

      // ch0: 1.0 -> 410, then 1.0 with a clear at ADD -> 778, then 1.0 -> 410
      set_data(0, 4096);
      In_req[0] = 1'b1;
      update(0, 410, 0, 1'b0, 1'b1, 1'b0);
      In_req[0] = 1'b1;
      update(0, 778, 0, 1'b1, 1'b1, 1'b0);
      In_req[0] = 1'b1;
      update(0, 410, 0, 1'b0, 1'b1, 1'b0);

      // ch0 again, reset lands during MUL_C
      In_req[0] = 1'b1;
      #1;
      n = 0;
      while (In_ack === 4'b0000 && n < 40) begin
         tick();
         n++;
      end
      chk("abort_ack", In_ack, 1);
      tick();
      In_req[0] = 1'b0;
      repeat (3) tick();
      chk("abort_busy", Busy, 1);
      RESET = 1'b0;
      tick();
      chk("abort_valid", Out_valid, 0);
      chk("abort_busy_low", Busy, 0);
      chk("abort_data", $signed(Out_data), 0);
      tick();
      chk("abort_valid2", Out_valid, 0);
      RESET = 1'b1;

      // pointer back at 0 and accumulators cleared
      set_data(3, 4096);
      In_req = 4'b1001;
      update(0, 410, 0, 1'b0, 1'b1, 1'b0);
      update(3, 410, 0, 1'b0, 1'b1, 1'b1);

      // all channels requesting: rotation, independence, saturation
      set_data(0, 4096);
      set_data(1, 32'h007FFFFF);
      set_data(2, 4096);
      set_data(3, 32'h00800000);
      In_req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         update(exp_ch[i], exp_y[i], exp_o[i], 1'b0, 1'b0, i > 0);
      end
      In_req = 4'b0000;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/leaky_integrator_scheduler.md
Name: leaky_integrator_scheduler

Overview:
- Time-multiplexes one leaky-integrator datapath across NCH independent channels.
- Per channel: acc_n = sat(x + alpha*acc_(n-1)); y = sat(alphaCap*acc_n).
- Contains a round-robin arbiter, a per-channel accumulator state file and one shared fixed-point multiplier, sequenced by an FSM.
- Sits between the per-channel sample producers and the downstream smoothing consumer. It replaces per-channel integrator instances.

Parameters:
- WI, 12, integer bits of all signed fixed-point values (W = WI+WF).
- WF, 12, fraction bits.
- NCH, 4, number of channels (2..16).
- ALPHA, 3686 (0.9 in Q12.12), feedback coefficient, W-bit signed.
- ALPHA_CAP, 410 (0.1 in Q12.12), output scale coefficient, W-bit signed.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous reset, active-low.
- In_req  in  NCH  per-channel request; held with In_data until acked.
- In_data  in  NCH*W  per-channel signed sample; channel k at bits [k*W +: W].
- In_ack  out  NCH  one-hot, one-cycle pulse; sample of that channel is captured.
- Clr  in  NCH  per-channel state clear (zeroes accumulator).
- Out_valid  out  1  one-cycle pulse; Out_ch/Out_data/Out_ovf are valid.
- Out_ch  out  clog2(NCH)  channel of the result.
- Out_data  out  W  signed smoothed output y.
- Out_ovf  out  1  saturation occurred in any step of this update.
- Busy  out  1  high in every non-IDLE state.

Behaviour:
- Reset (RESET=0 at an edge): FSM goes to IDLE and the round-robin pointer goes to 0. All accumulators are cleared to 0. In_ack=0, Out_valid=0, Out_ch=0, Out_data=0, Out_ovf=0, Busy=0.
- Reset mid-operation aborts the update. No Out_valid is issued and no state is written.
- FSM states: IDLE -> RD -> MUL_A -> ADD -> MUL_C -> OUT -> IDLE. All states except IDLE are unconditional, one cycle each.
- IDLE:
  - If any In_req is high, grant the first requesting channel at or after the pointer (wrapping).
  - Pulse In_ack for that channel this cycle, latch its In_data and channel index, and advance the pointer to granted+1 mod NCH.
  - If no request, stay in IDLE.
- RD: read acc[ch] into the operand register.
- MUL_A: prod = ALPHA*acc (2W-bit signed) >>> WF (arithmetic shift, floor), saturated to W bits.
- ADD: sum = x + prod, saturated to W bits; write the result back to acc[ch].
- MUL_C: y = sum*ALPHA_CAP >>> WF, saturated to W bits.
- OUT:
  - Registered Out_valid=1 with Out_ch, Out_data=y and Out_ovf (OR of all three saturation events).
  - Out_data, Out_ch and Out_ovf hold their value until the next OUT.
- Latency: In_ack at cycle g, Out_valid at g+5. Throughput is one update per 6 cycles; the next grant is no earlier than g+6.
- Saturation limits: max = 2^(W-1)-1, min = -2^(W-1).
- Fairness: a channel that holds In_req is granted within NCH grants.
- Clr[k]: zeroes acc[k] at that edge, in any state.
  - If Clr[k] coincides with the ADD writeback to channel k, the clear wins and acc[k]=0. The in-flight update still completes and outputs y computed from the unclear sum.
  - A Clr during RD/MUL_A of the same channel does not affect the already-read operand.
- In_req deasserted without an ack is allowed (request withdrawn). In_req of a channel currently in flight is ignored until IDLE.
- NCH not a power of two: the pointer wraps at NCH-1 -> 0.

Test Plan:
- Reset, then ch0 In_data=4096 (1.0) -> In_ack[0] pulse; 5 cycles later Out_valid, Out_ch=0, Out_data=410, acc[0]=4096.
- Second ch0 sample 4096 -> prod=3686, acc=7782, Out_data=778 (floor 3190620/4096), Out_ovf=0.
- All four In_req held high continuously -> grants in order 0,1,2,3,0 at 6-cycle spacing. Each channel's state is independent: ch2 fed 1.0 twice gives 410 then 778.
- ch1 fed max positive 0x7FFFFF repeatedly -> sum saturates at 0x7FFFFF, Out_ovf=1, Out_data=(8388607*410)>>12=839679. Negative min likewise clamps to 0x800000.
- Clr[0] asserted in the same cycle as the ADD writeback for ch0 -> Out_data still 778 for that update. The next 1.0 sample on ch0 yields 410.
- RESET low during MUL_C -> no Out_valid; after release all accumulators are 0 and the pointer is 0. The first grant goes to the lowest requesting channel.
